// File: rtl/thor_tlb_assoc.sv
// Set-associative TLB with flop storage, 1-cycle lookup, software write/read,
// invalid-first/round-robin replacement and a set-at-a-time ASID/global flush.
module thor_tlb_assoc #(
  parameter int VAW   = 32,
  parameter int PAW   = 32,
  parameter int PGW   = 12,
  parameter int SETS  = 16,
  parameter int WAYS  = 4,
  parameter int ASIDW = 8,
  localparam int SW   = $clog2(SETS),
  localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int TW   = VAW - PGW - SW,
  localparam int PNW  = PAW - PGW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             rdy_o,
  input  logic             req_i,
  input  logic [VAW-1:0]   vadr_i,
  input  logic             we_i,
  input  logic [ASIDW-1:0] asid_i,
  input  logic             xlaten_i,
  output logic             rsp_v_o,
  output logic [PAW-1:0]   padr_o,
  output logic [3:0]       acr_o,
  output logic             miss_o,
  input  logic             wr_i,
  input  logic             wr_rand_i,
  input  logic [WW-1:0]    wr_way_i,
  input  logic [VAW-1:0]   wr_vadr_i,
  input  logic [PNW-1:0]   wr_ppn_i,
  input  logic [ASIDW-1:0] wr_asid_i,
  input  logic [7:0]       wr_flags_i,
  input  logic             rd_i,
  input  logic [SW-1:0]    rd_set_i,
  input  logic [WW-1:0]    rd_way_i,
  output logic             rd_v_o,
  output logic [TW-1:0]    rd_tag_o,
  output logic [PNW-1:0]   rd_ppn_o,
  output logic [ASIDW-1:0] rd_asid_o,
  output logic [7:0]       rd_flags_o,
  input  logic             flush_i,
  input  logic             flush_all_i,
  input  logic [ASIDW-1:0] flush_asid_i
);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_e;

  // Flag bit positions within {V,G,D,A,C,R,W,X}
  localparam int FV = 7;
  localparam int FG = 6;
  localparam int FD = 5;
  localparam int FA = 4;

  logic [7:0]       flags_q [SETS][WAYS];
  logic [ASIDW-1:0] asid_q  [SETS][WAYS];
  logic [TW-1:0]    tag_q   [SETS][WAYS];
  logic [PNW-1:0]   ppn_q   [SETS][WAYS];

  state_e           state_q;
  logic [SW-1:0]    cnt_q;
  logic             fl_all_q;
  logic [ASIDW-1:0] fl_asid_q;
  logic [WW-1:0]    rr_q;

  logic             rdy_q, rsp_v_q, miss_q, rd_v_q;
  logic [PAW-1:0]   padr_q;
  logic [3:0]       acr_q;
  logic [TW-1:0]    rd_tag_q;
  logic [PNW-1:0]   rd_ppn_q;
  logic [ASIDW-1:0] rd_asid_q;
  logic [7:0]       rd_flags_q;

  logic [SW-1:0]    lk_set_s, wr_set_s;
  logic [TW-1:0]    lk_tag_s, wr_tag_s;
  logic [WAYS-1:0]  match_s;
  logic             hit_s, inv_any_s;
  logic [WW-1:0]    hit_way_s, inv_way_s, wsel_s, rd_w_s;
  logic             lk_go_s, wr_go_s, fl_go_s, rr_adv_s;
  logic             unused_s;

  assign lk_set_s = vadr_i[PGW+SW-1:PGW];
  assign lk_tag_s = vadr_i[VAW-1:PGW+SW];
  assign wr_set_s = wr_vadr_i[PGW+SW-1:PGW];
  assign wr_tag_s = wr_vadr_i[VAW-1:PGW+SW];
  assign unused_s = ^wr_vadr_i[PGW-1:0];

  assign lk_go_s  = (state_q == IDLE) && req_i;
  assign fl_go_s  = (state_q == IDLE) && flush_i;
  assign wr_go_s  = (state_q == IDLE) && wr_i && !flush_i;
  assign rr_adv_s = wr_go_s && wr_rand_i && !inv_any_s;
  assign rd_w_s   = (WAYS == 1) ? '0 : rd_way_i;

  // Hit detection (lowest way wins) and invalid-first victim search
  always_comb begin
    hit_s     = 1'b0;
    hit_way_s = '0;
    inv_any_s = 1'b0;
    inv_way_s = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      match_s[w] = flags_q[lk_set_s][w][FV] && (tag_q[lk_set_s][w] == lk_tag_s) &&
                   (flags_q[lk_set_s][w][FG] || (asid_q[lk_set_s][w] == asid_i));
      hit_s      = hit_s | match_s[w];
      hit_way_s  = match_s[w] ? WW'(w) : hit_way_s;
      inv_any_s  = inv_any_s | !flags_q[wr_set_s][w][FV];
      inv_way_s  = !flags_q[wr_set_s][w][FV] ? WW'(w) : inv_way_s;
    end
    if (WAYS == 1) begin
      wsel_s = '0;
    end else if (wr_rand_i) begin
      wsel_s = inv_any_s ? inv_way_s : rr_q;
    end else begin
      wsel_s = wr_way_i;
    end
  end

  // Entry storage: A/D update, flush invalidation, then software write (wins)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          flags_q[s][w] <= 8'h00;
          asid_q[s][w]  <= '0;
          tag_q[s][w]   <= '0;
          ppn_q[s][w]   <= '0;
        end
      end
    end else begin
      if (lk_go_s && xlaten_i && hit_s) begin
        flags_q[lk_set_s][hit_way_s][FA] <= 1'b1;
        if (we_i) flags_q[lk_set_s][hit_way_s][FD] <= 1'b1;
      end
      if (state_q == FLUSH) begin
        for (int w = 0; w < WAYS; w++) begin
          if (fl_all_q || ((asid_q[cnt_q][w] == fl_asid_q) && !flags_q[cnt_q][w][FG]))
            flags_q[cnt_q][w][FV] <= 1'b0;
        end
      end
      if (wr_go_s) begin
        flags_q[wr_set_s][wsel_s] <= wr_flags_i;
        asid_q[wr_set_s][wsel_s]  <= wr_asid_i;
        tag_q[wr_set_s][wsel_s]   <= wr_tag_s;
        ppn_q[wr_set_s][wsel_s]   <= wr_ppn_i;
      end
    end
  end

  // Control FSM, replacement pointer and all registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      fl_all_q   <= 1'b0;
      fl_asid_q  <= '0;
      rr_q       <= '0;
      rdy_q      <= 1'b1;
      rsp_v_q    <= 1'b0;
      padr_q     <= '0;
      acr_q      <= 4'h0;
      miss_q     <= 1'b0;
      rd_v_q     <= 1'b0;
      rd_tag_q   <= '0;
      rd_ppn_q   <= '0;
      rd_asid_q  <= '0;
      rd_flags_q <= 8'h00;
    end else begin
      rsp_v_q <= lk_go_s;
      if (lk_go_s) begin
        if (!xlaten_i) begin
          padr_q <= PAW'(vadr_i);
          acr_q  <= 4'hF;
          miss_q <= 1'b0;
        end else if (hit_s) begin
          padr_q <= {ppn_q[lk_set_s][hit_way_s], vadr_i[PGW-1:0]};
          acr_q  <= flags_q[lk_set_s][hit_way_s][3:0];
          miss_q <= 1'b0;
        end else begin
          padr_q <= '0;
          acr_q  <= 4'h0;
          miss_q <= 1'b1;
        end
      end

      rd_v_q <= rd_i;
      if (rd_i) begin
        rd_tag_q   <= tag_q[rd_set_i][rd_w_s];
        rd_ppn_q   <= ppn_q[rd_set_i][rd_w_s];
        rd_asid_q  <= asid_q[rd_set_i][rd_w_s];
        rd_flags_q <= flags_q[rd_set_i][rd_w_s];
      end

      if (rr_adv_s) rr_q <= (WAYS == 1) ? '0 : rr_q + WW'(1);

      case (state_q)
        IDLE: begin
          if (fl_go_s) begin
            state_q   <= FLUSH;
            cnt_q     <= '0;
            fl_all_q  <= flush_all_i;
            fl_asid_q <= flush_asid_i;
            rdy_q     <= 1'b0;
          end
        end
        FLUSH: begin
          cnt_q <= cnt_q + SW'(1);
          if (cnt_q == SW'(SETS - 1)) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign rdy_o      = rdy_q;
  assign rsp_v_o    = rsp_v_q;
  assign padr_o     = padr_q;
  assign acr_o      = acr_q;
  assign miss_o     = miss_q;
  assign rd_v_o     = rd_v_q;
  assign rd_tag_o   = rd_tag_q;
  assign rd_ppn_o   = rd_ppn_q;
  assign rd_asid_o  = rd_asid_q;
  assign rd_flags_o = rd_flags_q;

endmodule

// File: tb/tb_thor_tlb_assoc.sv
// Directed self-checking bench for thor_tlb_assoc (default parameters).
module tb_thor_tlb_assoc;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        rdy_o, rsp_v_o, miss_o, rd_v_o;
  logic        req_i = 1'b0, we_i = 1'b0, xlaten_i = 1'b1;
  logic [31:0] vadr_i = 32'h0;
  logic [7:0]  asid_i = 8'h0;
  logic [31:0] padr_o;
  logic [3:0]  acr_o;
  logic        wr_i = 1'b0, wr_rand_i = 1'b0;
  logic [1:0]  wr_way_i = 2'd0;
  logic [31:0] wr_vadr_i = 32'h0;
  logic [19:0] wr_ppn_i = 20'h0;
  logic [7:0]  wr_asid_i = 8'h0, wr_flags_i = 8'h0;
  logic        rd_i = 1'b0;
  logic [3:0]  rd_set_i = 4'h0;
  logic [1:0]  rd_way_i = 2'd0;
  logic [15:0] rd_tag_o;
  logic [19:0] rd_ppn_o;
  logic [7:0]  rd_asid_o, rd_flags_o;
  logic        flush_i = 1'b0, flush_all_i = 1'b0;
  logic [7:0]  flush_asid_i = 8'h0;

  int checks = 0;
  int errors = 0;
  int lowcnt, rsps;

  thor_tlb_assoc dut (
    .clk_i(clk_i), .rst_i(rst_i), .rdy_o(rdy_o),
    .req_i(req_i), .vadr_i(vadr_i), .we_i(we_i), .asid_i(asid_i), .xlaten_i(xlaten_i),
    .rsp_v_o(rsp_v_o), .padr_o(padr_o), .acr_o(acr_o), .miss_o(miss_o),
    .wr_i(wr_i), .wr_rand_i(wr_rand_i), .wr_way_i(wr_way_i), .wr_vadr_i(wr_vadr_i),
    .wr_ppn_i(wr_ppn_i), .wr_asid_i(wr_asid_i), .wr_flags_i(wr_flags_i),
    .rd_i(rd_i), .rd_set_i(rd_set_i), .rd_way_i(rd_way_i), .rd_v_o(rd_v_o),
    .rd_tag_o(rd_tag_o), .rd_ppn_o(rd_ppn_o), .rd_asid_o(rd_asid_o), .rd_flags_o(rd_flags_o),
    .flush_i(flush_i), .flush_all_i(flush_all_i), .flush_asid_i(flush_asid_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic lookup(input logic [31:0] va, input logic [7:0] asid, input logic we, input logic xl);
    req_i = 1'b1; vadr_i = va; asid_i = asid; we_i = we; xlaten_i = xl;
    tick();
    req_i = 1'b0; we_i = 1'b0; xlaten_i = 1'b1;
  endtask

  task automatic write(input logic [31:0] va, input logic [19:0] ppn, input logic [7:0] asid,
                       input logic [7:0] fl, input logic rnd, input logic [1:0] way);
    wr_i = 1'b1; wr_vadr_i = va; wr_ppn_i = ppn; wr_asid_i = asid;
    wr_flags_i = fl; wr_rand_i = rnd; wr_way_i = way;
    tick();
    wr_i = 1'b0; wr_rand_i = 1'b0;
  endtask

  task automatic read(input logic [3:0] s, input logic [1:0] w);
    rd_i = 1'b1; rd_set_i = s; rd_way_i = w;
    tick();
    rd_i = 1'b0;
  endtask

  // Called just after the edge that started a flush; counts rdy-low samples
  task automatic wait_flush(output int low, output int nrsp);
    low = 0;
    nrsp = 0;
    for (int i = 0; i < 40; i++) begin
      if (rdy_o) break;
      low++;
      tick();
      nrsp += int'(rsp_v_o);
    end
  endtask

  initial begin
    tick();
    check_eq("reset_rdy", rdy_o, 1);
    check_eq("reset_rsp_v", rsp_v_o, 0);
    check_eq("reset_padr", padr_o, 0);
    check_eq("reset_rd_v", rd_v_o, 0);
    rst_i = 1'b0;
    tick();

    lookup(32'h00401234, 8'd0, 1'b0, 1'b1);
    check_eq("cold_rsp_v", rsp_v_o, 1);
    check_eq("cold_miss", miss_o, 1);
    check_eq("cold_padr", padr_o, 0);
    check_eq("cold_rdy", rdy_o, 1);
    tick();
    check_eq("rsp_pulse", rsp_v_o, 0);

    lookup(32'hDEADBEEF, 8'd0, 1'b0, 1'b0);
    check_eq("bypass_padr", padr_o, 32'hDEADBEEF);
    check_eq("bypass_acr", acr_o, 4'hF);

    write(32'h00401000, 20'h12345, 8'd5, 8'h8F, 1'b0, 2'd2);
    lookup(32'h00401ABC, 8'd5, 1'b1, 1'b1);
    check_eq("hit_padr", padr_o, 32'h12345ABC);
    check_eq("hit_acr", acr_o, 4'hF);
    check_eq("hit_miss", miss_o, 0);
    read(4'd1, 2'd2);
    check_eq("rd_v", rd_v_o, 1);
    check_eq("rd_flags_ad", rd_flags_o, 8'hBF);
    check_eq("rd_tag", rd_tag_o, 16'h0040);
    check_eq("rd_ppn", rd_ppn_o, 20'h12345);
    check_eq("rd_asid", rd_asid_o, 8'd5);
    tick();
    check_eq("rd_v_drop", rd_v_o, 0);

    lookup(32'h00401ABC, 8'd6, 1'b0, 1'b1);
    check_eq("asid_miss", miss_o, 1);
    write(32'h00401000, 20'h12345, 8'd5, 8'hCF, 1'b0, 2'd2);
    lookup(32'h00401ABC, 8'd6, 1'b0, 1'b1);
    check_eq("global_hit_miss", miss_o, 0);
    check_eq("global_hit_padr", padr_o, 32'h12345ABC);

    // Duplicate tags: lowest way must win; lookup concurrent with a write sees old data
    write(32'h00405000, 20'h00333, 8'd1, 8'h8F, 1'b0, 2'd3);
    write(32'h00405000, 20'h00111, 8'd1, 8'h8F, 1'b0, 2'd1);
    lookup(32'h00405010, 8'd1, 1'b0, 1'b1);
    check_eq("multi_hit_low", padr_o, 32'h00111010);
    wr_i = 1'b1; wr_vadr_i = 32'h00405000; wr_ppn_i = 20'h00222; wr_asid_i = 8'd1;
    wr_flags_i = 8'h8F; wr_rand_i = 1'b0; wr_way_i = 2'd1;
    lookup(32'h00405020, 8'd1, 1'b0, 1'b1);
    wr_i = 1'b0;
    check_eq("wr_rd_old", padr_o, 32'h00111020);
    lookup(32'h00405020, 8'd1, 1'b0, 1'b1);
    check_eq("wr_rd_new", padr_o, 32'h00222020);

    flush_i = 1'b1; flush_all_i = 1'b1;
    tick();
    flush_i = 1'b0;
    wait_flush(lowcnt, rsps);
    check_eq("flush_all_len", lowcnt, 16);
    lookup(32'h00401ABC, 8'd6, 1'b0, 1'b1);
    check_eq("flush_all_miss", miss_o, 1);

    write(32'h00A01000, 20'h00100, 8'd5, 8'h8F, 1'b1, 2'd3);
    write(32'h00B01000, 20'h00101, 8'd5, 8'h8F, 1'b1, 2'd3);
    write(32'h00C01000, 20'h00102, 8'd5, 8'h8F, 1'b1, 2'd3);
    write(32'h00D01000, 20'h00103, 8'd5, 8'h8F, 1'b1, 2'd0);
    for (int w = 0; w < 4; w++) begin
      read(4'd1, 2'(w));
      check_eq("fill_ppn", rd_ppn_o, 64'h100 + 64'(w));
    end
    write(32'h00E01000, 20'h00104, 8'd5, 8'h8F, 1'b1, 2'd3);
    write(32'h00F01000, 20'h00105, 8'd5, 8'h8F, 1'b1, 2'd3);
    read(4'd1, 2'd0);
    check_eq("rr_way0", rd_ppn_o, 20'h00104);
    read(4'd1, 2'd1);
    check_eq("rr_way1", rd_ppn_o, 20'h00105);
    read(4'd1, 2'd2);
    check_eq("rr_way2_kept", rd_ppn_o, 20'h00102);

    write(32'h00402000, 20'h0AAAA, 8'd5, 8'hCF, 1'b0, 2'd0);
    write(32'h00403000, 20'h0BBBB, 8'd7, 8'h8F, 1'b0, 2'd1);
    flush_i = 1'b1; flush_all_i = 1'b0; flush_asid_i = 8'd5;
    lookup(32'h00402123, 8'd5, 1'b0, 1'b1);
    flush_i = 1'b0;
    check_eq("flush_lookup_rsp", rsp_v_o, 1);
    check_eq("flush_lookup_padr", padr_o, 32'h0AAAA123);
    check_eq("flush_rdy_low", rdy_o, 0);
    req_i = 1'b1; vadr_i = 32'h00C01456; asid_i = 8'd5;
    wr_i = 1'b1; wr_vadr_i = 32'h00503000; wr_ppn_i = 20'h0CCCC; wr_asid_i = 8'd9;
    wr_flags_i = 8'h8F; wr_way_i = 2'd0; wr_rand_i = 1'b0;
    wait_flush(lowcnt, rsps);
    req_i = 1'b0; wr_i = 1'b0;
    check_eq("flush_asid_len", lowcnt, 16);
    check_eq("flush_req_ignored", rsps, 0);
    lookup(32'h00402123, 8'd5, 1'b0, 1'b1);
    check_eq("flush_global_kept", padr_o, 32'h0AAAA123);
    lookup(32'h00C01456, 8'd5, 1'b0, 1'b1);
    check_eq("flush_asid_gone", miss_o, 1);
    lookup(32'h00403789, 8'd7, 1'b0, 1'b1);
    check_eq("flush_other_asid", padr_o, 32'h0BBBB789);
    read(4'd3, 2'd0);
    check_eq("flush_wr_ignored", rd_flags_o, 8'h00);

    flush_i = 1'b1; flush_all_i = 1'b0; flush_asid_i = 8'd7;
    tick();
    flush_i = 1'b0;
    tick();
    tick();
    #2 rst_i = 1'b1;
    #1;
    check_eq("async_rst_rdy", rdy_o, 1);
    tick();
    rst_i = 1'b0;
    lookup(32'h00402123, 8'd5, 1'b0, 1'b1);
    check_eq("rst_global_miss", miss_o, 1);
    lookup(32'h00403789, 8'd7, 1'b0, 1'b1);
    check_eq("rst_asid7_miss", miss_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
